// File: rtl/decoder_fifo.sv
// Two-entry FIFO of 3-bit codes with a one-hot decode of the head entry.
// Define DECODER_SWEEP_EN to add a self-test sweep that pushes codes 0..7 in order.
module decoder_fifo (
    input  logic       clk,
    input  logic       rst_n,
`ifdef DECODER_SWEEP_EN
    input  logic       sweep_start,
    output logic       sweep_busy,
`endif
    input  logic [2:0] din,
    input  logic       din_valid,
    output logic       din_ready,
    output logic [7:0] dout,
    output logic       dout_valid,
    input  logic       dout_ready,
    output logic [1:0] level
);

    logic [2:0] mem [2];
    logic       wr_ptr;
    logic       rd_ptr;
    logic [1:0] level_q;

    logic       sweep_push;
    logic [2:0] sweep_code;
    logic       sweep_active;

    logic       push;
    logic       pop;
    logic [2:0] push_data;

`ifdef DECODER_SWEEP_EN
    typedef enum logic {IDLE, SWEEP} state_t;

    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sweep_push = 1'b0;
        case (state_q)
            IDLE: begin
                if (sweep_start && (level_q == 2'd0)) begin
                    state_d = SWEEP;
                    cnt_d   = 3'd0;
                end
            end
            SWEEP: begin
                // Stall the sweep while the buffer is full; leave on the push of code 7.
                if (level_q != 2'd2) begin
                    sweep_push = 1'b1;
                    cnt_d      = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign sweep_code   = cnt_q;
    assign sweep_active = (state_q == SWEEP);
    assign sweep_busy   = sweep_active;
`else
    assign sweep_push   = 1'b0;
    assign sweep_code   = 3'd0;
    assign sweep_active = 1'b0;
`endif

    assign din_ready  = rst_n && (level_q != 2'd2) && !sweep_active;
    assign dout_valid = (level_q != 2'd0);
    assign dout       = dout_valid ? (8'd1 << mem[rd_ptr]) : 8'h00;
    assign level      = level_q;

    // Sweep pushes and external pushes are mutually exclusive (din_ready is low in SWEEP).
    assign push      = sweep_push || (din_valid && din_ready);
    assign pop       = dout_valid && dout_ready;
    assign push_data = sweep_push ? sweep_code : din;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            level_q <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            level_q <= level_q + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule
